// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bundle: CPU port (0), loader/DMA port (1) and the memory side.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic              memWE;
  logic              memRE;
  logic [DATA_W-1:0] memRData;

  logic              cpuStall;

  // Handshake: a requester raises reqP with weP/addrP/wdataP and holds them until it
  // samples ackP=1; the arbiter latches them when it accepts, so later changes are ignored.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memRData,
    output ack0, rdata0, ack1, rdata1, memAddr, memWData, memWE, memRE, cpuStall
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memRData,
    input  ack0, rdata0, ack1, rdata1, memAddr, memWData, memWE, memRE, cpuStall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU port and a loader port.
// Each access: IDLE (accept) -> ISSUE -> [RWAIT for reads] -> DONE (one-cycle ack).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RWAIT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last_gnt;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_mem_we;
  logic              r_mem_re;

  logic              w_any_req;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any_req   = bus.req0 | bus.req1;
  // On a tie the port that did not win last time gets the grant.
  assign w_winner    = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;
  assign w_sel_we    = w_winner ? bus.we1    : bus.we0;
  assign w_sel_addr  = w_winner ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_port     <= w_winner;
            r_last_gnt <= w_winner;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_mem_we   <= w_sel_we;
            r_mem_re   <= ~w_sel_we;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_ack0  <= ~r_port;
            r_ack1  <= r_port;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (r_port) r_rdata1 <= bus.memRData;
          else        r_rdata0 <= bus.memRData;
          r_ack0  <= ~r_port;
          r_ack1  <= r_port;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.memAddr  = r_addr;
  assign bus.memWData = r_wdata;
  assign bus.memWE    = r_mem_we;
  assign bus.memRE    = r_mem_re;
  assign bus.cpuStall = bus.req0 & ~r_ack0;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic, checked against a
// transaction-level model (round-robin, fixed latency) and a per-port expected-rdata queue.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [15:0] env_mem [logic [15:0]];

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    if (bus.memWE) env_mem[bus.memAddr] = bus.memWData;
    bus.memRData <= bus.memRE ? env_rd(bus.memAddr) : 16'hDEAD;
  end

  // ---------------- reference memory + scoreboard queues ----------------
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] drv_rdata [2];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          grant_log[$];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hA5C3;
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input bit p, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, input bit drop);
    logic [15:0] exp_v;
    bit got;
    @(negedge clk);
    if (we) begin
      ref_mem[addr] = wd;
      exp_v = drv_rdata[p];
    end else begin
      exp_v = ref_rd(addr);
      drv_rdata[p] = exp_v;
    end
    if (p == 1'b0) begin
      exp_q0.push_back(exp_v);
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end else begin
      exp_q1.push_back(exp_v);
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 1'b0 && bus.ack0) || (p == 1'b1 && bus.ack1)) begin
        got = 1'b1;
        break;
      end
    end
    check(p ? "ack1_arrived" : "ack0_arrived", {31'd0, got}, 32'd1);
    if (drop) begin
      if (p == 1'b0) bus.req0 = 1'b0;
      else           bus.req1 = 1'b0;
    end
  endtask

  // ---------------- monitor: transaction model + scoreboard ----------------
  bit          m_busy = 1'b0;
  int          m_cyc  = 0;
  int          m_lat  = 0;
  bit          m_last = 1'b1;
  bit          m_port = 1'b0;
  bit          m_we   = 1'b0;
  logic [15:0] m_addr   = 16'h0;
  logic [15:0] m_wdata  = 16'h0;
  logic [15:0] m_rdata0 = 16'h0;
  logic [15:0] m_rdata1 = 16'h0;

  initial begin
    bit s_req0, s_req1, s_we0, s_we1, e_ack0, e_ack1, win;
    logic [15:0] s_addr0, s_addr1, s_wd0, s_wd1, popped;
    forever begin
      @(posedge clk);
      s_req0 = bus.req0;  s_req1 = bus.req1;
      s_we0  = bus.we0;   s_we1  = bus.we1;
      s_addr0 = bus.addr0; s_addr1 = bus.addr1;
      s_wd0  = bus.wdata0; s_wd1  = bus.wdata1;
      #1;
      if (!reset) begin
        m_busy = 1'b0; m_last = 1'b1; m_addr = 16'h0; m_wdata = 16'h0;
        m_rdata0 = 16'h0; m_rdata1 = 16'h0;
        check("rst_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check("rst_mem_en", {30'd0, bus.memWE, bus.memRE}, 32'd0);
        check("rst_mem_bus", {bus.memAddr, bus.memWData}, 32'd0);
        check("rst_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        continue;
      end
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (m_busy) begin
        m_cyc++;
        if (m_cyc == m_lat) begin
          if (m_port) e_ack1 = 1'b1;
          else        e_ack0 = 1'b1;
        end
        if (m_cyc == m_lat + 1) m_busy = 1'b0;
      end else if (s_req0 || s_req1) begin
        win     = (s_req0 && s_req1) ? ~m_last : s_req1;
        m_last  = win;
        m_port  = win;
        m_we    = win ? s_we1   : s_we0;
        m_addr  = win ? s_addr1 : s_addr0;
        m_wdata = win ? s_wd1   : s_wd0;
        m_lat   = m_we ? 1 : 2;
        m_cyc   = 0;
        m_busy  = 1'b1;
      end
      check("ack0", {31'd0, bus.ack0}, {31'd0, e_ack0});
      check("ack1", {31'd0, bus.ack1}, {31'd0, e_ack1});
      check("memWE", {31'd0, bus.memWE}, {31'd0, m_busy && m_cyc == 0 && m_we});
      check("memRE", {31'd0, bus.memRE}, {31'd0, m_busy && m_cyc == 0 && !m_we});
      check("memAddr", {16'd0, bus.memAddr}, {16'd0, m_addr});
      check("memWData", {16'd0, bus.memWData}, {16'd0, m_wdata});
      check("cpuStall", {31'd0, bus.cpuStall}, {31'd0, bus.req0 & ~e_ack0});
      if (e_ack0 || e_ack1) begin
        grant_log.push_back(e_ack1 ? 1 : 0);
        if (e_ack1 ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else if (e_ack1) begin
          popped = exp_q1.pop_front();
          m_rdata1 = popped;
        end else begin
          popped = exp_q0.pop_front();
          m_rdata0 = popped;
        end
      end
      check("rdata0", {16'd0, bus.rdata0}, {16'd0, m_rdata0});
      check("rdata1", {16'd0, bus.rdata1}, {16'd0, m_rdata1});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- random traffic per port ----------------
  task automatic rand_port(input bit p, input int n);
    logic [15:0] base;
    int gap;
    bit keep;
    base = p ? 16'h0040 : 16'h3000;
    for (int i = 0; i < n; i++) begin
      gap  = $urandom_range(0, 3);
      keep = (gap == 0) && ($urandom_range(0, 1) == 1) && (i != n - 1);
      do_access(p, $urandom_range(0, 1) == 1, base + 16'($urandom_range(0, 7)),
                16'($urandom), !keep);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drv_rdata[0] = 16'h0;
    drv_rdata[1] = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    reset = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 16'h0; bus.wdata0 = 16'h0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 16'h0; bus.wdata1 = 16'h0;
    drv_rdata[0] = 16'h0;
    drv_rdata[1] = 16'h0;
    env_mem[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // single CPU read, single loader write, loader read-back
    do_access(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1);
    check("cpu_read_0x3000", {16'd0, bus.rdata0}, 32'h1234);
    do_access(1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1);
    check("loader_write_keeps_rdata1", {16'd0, bus.rdata1}, 32'h0);
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1);

    // contention right after reset: both held, grants must alternate starting with CPU
    apply_reset();
    grant_log.delete();
    fork
      begin
        do_access(1'b0, 1'b1, 16'h3004, 16'hAAAA, 1'b0);
        do_access(1'b0, 1'b0, 16'h3004, 16'h0000, 1'b1);
      end
      begin
        do_access(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0);
        do_access(1'b1, 1'b1, 16'h0042, 16'h1111, 1'b1);
      end
    join
    check("contention_grants", {28'd0, grant_log.size() == 4 ? 1'b1 : 1'b0,
                                grant_log.size() == 4 ? grant_log[0][0] : 1'b1,
                                grant_log.size() == 4 ? grant_log[1][0] : 1'b0,
                                grant_log.size() == 4 ? grant_log[2][0] : 1'b1},
          32'b1_0_1_0);
    check("contention_last", {31'd0, grant_log.size() == 4 ? grant_log[3][0] : 1'b0}, 32'd1);

    // reset mid-read: abandon with no ack, then a fresh read completes
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h3002;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.memRE) begin seen = 1'b1; break; end
    end
    check("midread_issue_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midread_rst_memRE", {31'd0, bus.memRE}, 32'd0);
    check("midread_rst_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    @(negedge clk);
    bus.req0 = 1'b0;
    drv_rdata[0] = 16'h0;
    drv_rdata[1] = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_access(1'b0, 1'b0, 16'h3002, 16'h0000, 1'b1);

    // back-to-back CPU with address change while req stays high
    do_access(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    do_access(1'b0, 1'b0, 16'h3001, 16'h0000, 1'b1);

    // single-cycle request pulse; address changed during ISSUE must be ignored
    @(negedge clk);
    exp_q0.push_back(ref_rd(16'h300A));
    drv_rdata[0] = ref_rd(16'h300A);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h300A;
    @(negedge clk);
    bus.req0 = 1'b0; bus.addr0 = 16'h3555;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack0) begin seen = 1'b1; break; end
    end
    check("glitch_ack0", {31'd0, seen}, 32'd1);

    // random two-port traffic on disjoint address windows
    fork
      rand_port(1'b0, 40);
      rand_port(1'b1, 40);
    join

    repeat (6) @(negedge clk);
    check("scoreboard_drained", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
